color_pio_bank: RTL and testbench
=================================

// Module: color_pio_bank
// PURPOSE
//   Parametrised Avalon-MM output-register bank driving NCH colour/control words to the display path.
//   Each channel has a CPU-writable shadow register and an active register that drives out_port.
//   Shadow-to-active commit happens on a vsync rising edge, so colour changes never tear mid-frame.
//   Optional per-channel blink (compile-time). Sits on the QSYS fabric next to the video pipeline.
// PARAMETERS
//   NCH      4   number of channels (1..8)
//   WIDTH    24  bits per channel (1..32)
//   ADDR_W   4   Avalon word-address width; NCH+4 <= 2**ADDR_W
//   BLINK_W  24  blink period counter width
// PORTS
//   clk            in   1          system clock
//   reset_n        in   1          synchronous, active-low reset
//   address        in   ADDR_W     Avalon word address
//   chipselect     in   1          Avalon select
//   write_n        in   1          Avalon write strobe, active-low
//   writedata      in   32         Avalon write data
//   readdata       out  32         Avalon read data, zero wait states, combinational
//   vsync          in   1          frame sync, already synchronous to clk
//   out_port       out  NCH*WIDTH  active channel values; channel i at [i*WIDTH +: WIDTH]
//   commit_pending out  1          a commit is armed and waiting for vsync
//   commit_done    out  1          one-cycle pulse after each vsync commit
// BEHAVIOUR
//   Reset: reset_n sampled low at posedge clk clears shadow, active, CTRL, pending, blink regs,
//     vsync_q, counter and phase. All outputs read 0 the cycle after.
//   wr = chipselect & ~write_n. Writes take effect at the next posedge. WIDTH<32 stores writedata[WIDTH-1:0].
//   Map: 0..NCH-1 SHADOW[i] (RW); NCH CTRL; NCH+1 STATUS (RO); NCH+2 BLINK_MASK; NCH+3 BLINK_PERIOD.
//   Unmapped addresses read 0 and writes to them are ignored.
//   CTRL bit0 COMMIT: write-1 sets pending and reads 0. CTRL bit1 IMMEDIATE: RW.
//   STATUS bit0 = pending.
//   vsync_rise = vsync & ~vsync_q, where vsync_q is registered each cycle.
//   Commit: if pending & vsync_rise, then active <= shadow (all channels), pending <= 0,
//     and commit_done = 1 on the following cycle only.
//   Simultaneous COMMIT write and vsync_rise: pending is set and this edge does NOT commit;
//     the commit happens on the next rising edge.
//   A shadow write in the same cycle as a commit: active gets the old shadow; the new value lands in shadow.
//   IMMEDIATE=1: a SHADOW[i] write also loads active[i] in the same cycle. vsync commit still operates.
//   Reset mid-pending: pending is cleared and no commit_done pulse is issued.
//   readdata: SHADOW reads return shadow, not active, zero-extended to 32 bits.
// CONFIGURATION
//   COLOR_PIO_BLINK_EN defined:
//     - A counter counts 0..BLINK_PERIOD-1 and wraps.
//     - phase toggles on each wrap.
//     - out_port channel i = 0 when BLINK_MASK[i] & phase; otherwise it shows active[i].
//     - BLINK_PERIOD = 0 holds the counter and phase at 0.
//     - A BLINK_PERIOD write restarts the counter at 0 and sets phase to 0.
//   COLOR_PIO_BLINK_EN undefined:
//     - BLINK_MASK and BLINK_PERIOD read 0, and writes to them are ignored.
//     - out_port = active. No counter logic.
// STRUCTURE
//   Package color_pio_pkg: register offset constants (OFS_CTRL rel. NCH, etc.), CTRL/STATUS bit indices.
//   Sub-module color_pio_blink_timer (BLINK_W): period in, restart in, phase out. Instantiated only under the macro.
//   Top holds the register file, vsync edge detect, commit FSM (IDLE -> ARMED -> IDLE) and read mux.
// TESTING
//   1 Reset: write all regs, then hold reset_n=0 for 1 clk -> out_port=0, readdata=0, commit_pending=0.
//   2 Commit: SHADOW[0]=0xFF0000, CTRL=1 -> pending=1, out unchanged.
//     vsync 0->1 -> next clk ch0=0xFF0000, commit_done for 1 clk.
//   3 Race: CTRL=1 in the same cycle as vsync_rise -> no commit. Next vsync_rise commits.
//   4 Immediate: CTRL=2, SHADOW[2]=0x00FF00 -> out ch2=0x00FF00 next clk, no vsync needed.
//   5 Blink (macro on): MASK=1, PERIOD=4, ch0 active=0x123456 -> ch0 alternates 0x123456 / 0 every 4 clks.
//     PERIOD=0 -> steady 0x123456.
//   6 Map: read address NCH+4 -> 0. Macro off: read BLINK_MASK -> 0 after writing 0xF.

Source files
------------

// File: rtl/color_pio_pkg.sv
// Shared register-map offsets, control/status bit positions and commit FSM states
// for the vsync-committed colour PIO bank.
package color_pio_pkg;

  // Offsets of the control registers relative to the first address past the shadows.
  localparam int OFS_CTRL         = 0;
  localparam int OFS_STATUS       = 1;
  localparam int OFS_BLINK_MASK   = 2;
  localparam int OFS_BLINK_PERIOD = 3;

  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_IMM_BIT     = 1;
  localparam int STATUS_PEND_BIT  = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } commit_st_e;

  function automatic int reg_addr(input int nch, input int ofs);
    return nch + ofs;
  endfunction

endpackage

// File: rtl/color_pio_blink_timer.sv
// Free-running blink timer: counts 0..period-1, toggles phase on each wrap.
// A zero period or a restart parks counter and phase at 0.
module color_pio_blink_timer #(
  parameter int BLINK_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BLINK_W-1:0] i_period,
  input  logic               i_restart,
  output logic               o_phase
);

  logic [BLINK_W-1:0] r_cnt;
  logic               r_phase;

  always_ff @(posedge clk) begin
    if (!reset_n || i_restart || (i_period == '0)) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == i_period - BLINK_W'(1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + BLINK_W'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/color_pio_bank.sv
// Avalon-MM colour register bank: CPU writes shadows, vsync rising edge commits them to out_port.
// Optional per-channel blink is compiled in when COLOR_PIO_BLINK_EN is defined.
module color_pio_bank
  import color_pio_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WIDTH   = 24,
  parameter int ADDR_W  = 4,
  parameter int BLINK_W = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic                 vsync,
  output logic [NCH*WIDTH-1:0] out_port,
  output logic                 commit_pending,
  output logic                 commit_done
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(reg_addr(NCH, OFS_CTRL));
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(reg_addr(NCH, OFS_STATUS));
`ifdef COLOR_PIO_BLINK_EN
  localparam logic [ADDR_W-1:0] A_BMASK  = ADDR_W'(reg_addr(NCH, OFS_BLINK_MASK));
  localparam logic [ADDR_W-1:0] A_BPER   = ADDR_W'(reg_addr(NCH, OFS_BLINK_PERIOD));
`endif

  logic [WIDTH-1:0] r_shadow [NCH];
  logic [WIDTH-1:0] r_active [NCH];
  logic             r_imm;
  logic             r_vsync_q;
  logic             r_done;
  commit_st_e       r_state;
  commit_st_e       w_state_nxt;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_commit_wr;
  logic             w_vsync_rise;
  logic             w_commit;
  logic [NCH-1:0]   w_wr_ch;
  logic             w_unused_wd;

  assign w_wr         = chipselect & ~write_n;
  assign w_wr_ctrl    = w_wr && (address == A_CTRL);
  assign w_commit_wr  = w_wr_ctrl & writedata[CTRL_COMMIT_BIT];
  assign w_vsync_rise = vsync & ~r_vsync_q;
  assign w_unused_wd  = ^writedata;

  always_comb begin
    w_wr_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      w_wr_ch[i] = w_wr && (address == ADDR_W'(i));
    end
  end

  // Commit FSM: a COMMIT write arms it; an arming write on the same edge as vsync
  // wins, so the commit waits for the following rising edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_vsync_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_commit;
      r_vsync_q <= vsync;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_commit_wr) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_vsync_rise && !w_commit_wr) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Register file. An immediate-mode shadow write overrides a coincident commit on that channel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_imm <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wr_ctrl) r_imm <= writedata[CTRL_IMM_BIT];
      for (int i = 0; i < NCH; i++) begin
        if (w_commit) r_active[i] <= r_shadow[i];
        if (w_wr_ch[i]) begin
          r_shadow[i] <= writedata[WIDTH-1:0];
          if (r_imm) r_active[i] <= writedata[WIDTH-1:0];
        end
      end
    end
  end

`ifdef COLOR_PIO_BLINK_EN
  logic [NCH-1:0]     r_blink_mask;
  logic [BLINK_W-1:0] r_blink_period;
  logic               w_bper_wr;
  logic               w_phase;

  assign w_bper_wr = w_wr && (address == A_BPER);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_blink_mask   <= '0;
      r_blink_period <= '0;
    end else begin
      if (w_wr && (address == A_BMASK)) r_blink_mask <= writedata[NCH-1:0];
      if (w_bper_wr) r_blink_period <= writedata[BLINK_W-1:0];
    end
  end

  color_pio_blink_timer #(
    .BLINK_W (BLINK_W)
  ) u_blink_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_period  (r_blink_period),
    .i_restart (w_bper_wr),
    .o_phase   (w_phase)
  );
`endif

  always_comb begin
    out_port = '0;
    for (int i = 0; i < NCH; i++) begin
      out_port[i*WIDTH +: WIDTH] = r_active[i];
`ifdef COLOR_PIO_BLINK_EN
      if (r_blink_mask[i] && w_phase) out_port[i*WIDTH +: WIDTH] = '0;
`endif
    end
  end

  // Zero-wait-state read mux; COMMIT always reads back as 0.
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (address == ADDR_W'(i)) readdata[WIDTH-1:0] = r_shadow[i];
    end
    if (address == A_CTRL)   readdata[CTRL_IMM_BIT]    = r_imm;
    if (address == A_STATUS) readdata[STATUS_PEND_BIT] = (r_state == ST_ARMED);
`ifdef COLOR_PIO_BLINK_EN
    if (address == A_BMASK)  readdata[NCH-1:0]         = r_blink_mask;
    if (address == A_BPER)   readdata[BLINK_W-1:0]     = r_blink_period;
`endif
  end

  assign commit_pending = (r_state == ST_ARMED);
  assign commit_done    = r_done;

endmodule

// File: tb/tb_color_pio_bank.sv
// Scoreboard bench for color_pio_bank: driver pushes per-cycle expectations from a
// behavioural model, a negedge monitor pops and compares them against the outputs.
module tb_color_pio_bank;

  localparam int NCH = 4, WIDTH = 24, ADDR_W = 4, BLINK_W = 24;
  localparam logic [WIDTH-1:0] WMASK = {WIDTH{1'b1}};

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [ADDR_W-1:0]    address = '0;
  logic                 chipselect = 1'b0;
  logic                 write_n = 1'b1;
  logic [31:0]          writedata = '0;
  logic [31:0]          readdata;
  logic                 vsync = 1'b0;
  logic [NCH*WIDTH-1:0] out_port;
  logic                 commit_pending;
  logic                 commit_done;

  color_pio_bank #(.NCH(NCH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .BLINK_W(BLINK_W)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .vsync(vsync),
    .out_port(out_port), .commit_pending(commit_pending), .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                   chk;
    logic [NCH*WIDTH-1:0] op;
    logic [31:0]          rd;
    logic                 pend;
    logic                 done;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit               m_known = 0;
  logic [WIDTH-1:0] m_sh [NCH];
  logic [WIDTH-1:0] m_ac [NCH];
  bit               m_pend, m_imm, m_done, m_vq;
  logic [NCH-1:0]   m_mask;
  int unsigned      m_per;
  int unsigned      m_t;
  bit               vs_cur = 0;

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = 0;
    if (a < NCH) r = 32'(m_sh[a]);
    else if (a == NCH) r = {30'd0, m_imm, 1'b0};
    else if (a == NCH + 1) r = {31'd0, m_pend};
`ifdef COLOR_PIO_BLINK_EN
    else if (a == NCH + 2) r = 32'(m_mask);
    else if (a == NCH + 3) r = m_per;
`endif
    return r;
  endfunction

  function automatic logic [NCH*WIDTH-1:0] m_out();
    logic [NCH*WIDTH-1:0] o;
    bit blank;
    o = '0;
    for (int i = 0; i < NCH; i++) begin
      blank = 0;
`ifdef COLOR_PIO_BLINK_EN
      if (m_per != 0) blank = m_mask[i] && (((m_t / m_per) % 2) == 1);
`endif
      o[i*WIDTH +: WIDTH] = blank ? '0 : m_ac[i];
    end
    return o;
  endfunction

  task automatic m_edge(input bit rn, input bit cs, input bit wn, input int a,
                        input logic [31:0] wd, input bit vs);
    bit wr, rise, cwr, commit;
    logic [WIDTH-1:0] old_sh [NCH];
    if (!rn) begin
      m_known = 1; m_pend = 0; m_imm = 0; m_done = 0; m_vq = 0;
      m_mask = '0; m_per = 0; m_t = 0;
      for (int i = 0; i < NCH; i++) begin m_sh[i] = '0; m_ac[i] = '0; end
      return;
    end
    wr     = cs && !wn;
    rise   = vs && !m_vq;
    cwr    = wr && (a == NCH) && wd[0];
    commit = m_pend && rise && !cwr;
    for (int i = 0; i < NCH; i++) old_sh[i] = m_sh[i];
    if (commit) for (int i = 0; i < NCH; i++) m_ac[i] = old_sh[i];
    if (wr && a < NCH) begin
      m_sh[a] = wd[WIDTH-1:0];
      if (m_imm) m_ac[a] = wd[WIDTH-1:0];
    end
    if (cwr) m_pend = 1; else if (commit) m_pend = 0;
    m_done = commit;
    if (wr && a == NCH) m_imm = wd[1];
    m_vq = vs;
`ifdef COLOR_PIO_BLINK_EN
    if (wr && a == NCH + 2) m_mask = wd[NCH-1:0];
    if (wr && a == NCH + 3) begin m_per = 32'(wd[BLINK_W-1:0]); m_t = 0; end
    else if (m_per != 0) m_t++;
`endif
  endtask

  // One clock cycle: drive inputs, queue expectation, advance model on the edge.
  task automatic step(input bit rn, input bit cs, input bit wn, input int a,
                      input logic [31:0] wd, input bit vs);
    exp_t e;
    reset_n = rn; chipselect = cs; write_n = wn; address = ADDR_W'(a);
    writedata = wd; vsync = vs;
    e.chk  = m_known;
    e.op   = m_out();
    e.rd   = m_read(a);
    e.pend = m_pend;
    e.done = m_done;
    q.push_back(e);
    @(posedge clk);
    m_edge(rn, cs, wn, a, wd, vs);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    step(1, 1, 0, a, d, vs_cur);
  endtask

  task automatic rd(input int a);
    step(1, 0, 1, a, 32'hDEAD_BEEF, vs_cur);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, NCH + 1, 0, vs_cur);
  endtask

  task automatic setvs(input bit v);
    vs_cur = v;
    step(1, 0, 1, NCH + 1, 0, vs_cur);
  endtask

  task automatic chk(input string nm, input logic [NCH*WIDTH-1:0] act,
                     input logic [NCH*WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        chk("out_port", out_port, e.op);
        chk("readdata", 96'(readdata), 96'(e.rd));
        chk("commit_pending", 96'(commit_pending), 96'(e.pend));
        chk("commit_done", 96'(commit_done), 96'(e.done));
      end
    end
  end

  initial begin
    int a, r;
    logic [31:0] d;
    @(posedge clk); #1;
    step(0, 0, 1, 0, 0, 0);
    // Reset after loading every register
    for (int i = 0; i < NCH + 4; i++) wr(i, $urandom);
    wr(NCH, 32'h2);
    wr(1, 32'hABCDEF);
    step(0, 0, 1, NCH + 1, 0, 0);
    for (int i = 0; i < NCH + 2; i++) rd(i);
    // Deferred commit
    wr(0, 32'hFF0000);
    wr(NCH, 32'h1);
    rd(NCH + 1);
    idle(2);
    setvs(1);
    idle(2);
    setvs(0);
    // COMMIT write racing a vsync rising edge
    wr(1, 32'h0000AA);
    vs_cur = 1;
    step(1, 1, 0, NCH, 32'h1, 1);
    idle(2);
    setvs(0);
    wr(1, 32'h0000BB);
    setvs(1);
    idle(2);
    setvs(0);
    // Immediate mode, then a vsync commit while immediate is on
    wr(NCH, 32'h2);
    wr(2, 32'h00FF00);
    rd(2);
    rd(NCH);
    wr(3, 32'h777777);
    wr(NCH, 32'h3);
    wr(0, 32'h135790);
    setvs(1);
    idle(1);
    setvs(0);
    wr(NCH, 32'h0);
`ifdef COLOR_PIO_BLINK_EN
    wr(0, 32'h123456);
    wr(NCH, 32'h1);
    setvs(1);
    setvs(0);
    wr(NCH + 2, 32'h1);
    wr(NCH + 3, 32'd4);
    idle(18);
    wr(NCH + 3, 32'd0);
    idle(6);
    wr(NCH + 3, 32'd1);
    idle(4);
    wr(NCH + 3, 32'd0);
`endif
    // Map holes and blink registers
    wr(NCH + 2, 32'hF);
    rd(NCH + 2);
    rd(NCH + 4);
    wr(NCH + 4, 32'h5);
    rd(NCH + 4);
    rd(15);
    wr(NCH + 2, 32'h0);
    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 99) < 15) vs_cur = ~vs_cur;
      a = $urandom_range(0, NCH + 5);
      d = $urandom;
      if (a == NCH + 3) d = $urandom_range(0, 6);
      if (r < 2) step(0, 0, 1, a, d, vs_cur);
      else if (r < 50) step(1, 1, 0, a, d, vs_cur);
      else step(1, $urandom_range(0, 1), 1, a, d, vs_cur);
    end
    idle(2);
    @(negedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
